bus_distributor_4_outputs: RTL
==============================

# bus_distributor_4_outputs

Registered 1-to-4 bus distributor with valid/ready handshakes. It is the fan-out counterpart of the 4-input OR gate bus. It takes one NrOfBits-wide input stream and delivers each accepted word to one output channel, to a round-robin channel, or to all four channels. Per-channel bubble inversion is applied on the way out. It sits between a single producer and up to four gate-level consumers in the Logisim-generated datapath.

## Interface
- NrOfBits, default 1: width of the input bus and of each output bus.
- BubblesMask, default 4'b0000: bit k-1 set inverts every bit of the data loaded into channel k.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  NrOfBits  input word.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block accepts this cycle (combinational).
- in_sel  input  2  target channel in addressed mode: 0→ch1 … 3→ch4.
- in_auto  input  1  round-robin mode; in_sel is ignored.
- in_bcast  input  1  broadcast to all four channels; overrides in_auto and in_sel.
- outK_data  output  NrOfBits  channel K word, K=1..4.
- outK_valid  output  1  channel K slot holds a word.
- outK_ready  input  1  consumer K takes the word.

## Operation
- Each channel has one output slot, made of a data register and a valid flag. Outputs are driven directly from the slot registers.
- Slot K is free when !outK_valid, or when outK_valid && outK_ready (same-cycle drain-and-refill allowed).
- Target selection, in priority order:
  - in_bcast = 1: all four slots.
  - else in_auto = 1: slot rr_ptr+1.
  - else: slot in_sel+1.
- in_ready is computed as follows:
  - Broadcast: all four slots free.
  - Otherwise: the targeted slot free.
  - in_ready is a combinational function of the slot valids, the outK_ready inputs, in_bcast, in_auto, in_sel and rr_ptr. It does not depend on in_valid.
- Transfer happens when in_valid && in_ready. Each targeted slot loads in_data ^ {NrOfBits{BubblesMask[K-1]}} and sets valid = 1.
- A slot that is not loaded and has outK_valid && outK_ready clears its valid. Its data register keeps its last value.
- A slot with valid && !ready holds its data and valid unchanged. Output data never changes while valid is high and the word is not taken.
- rr_ptr is a 2-bit register:
  - Increments by 1 (wrapping 3→0) on each transfer made in auto mode.
  - Holds on addressed and broadcast transfers, and on cycles with no transfer.
- in_sel, in_auto and in_bcast are sampled only in the transfer cycle. The producer must hold in_valid and in_data stable until accepted. The block does not check this.
- Broadcast is all-or-nothing: no slot loads unless all four are free.
- No word is dropped or duplicated. Each accepted non-broadcast word appears on exactly one channel; each accepted broadcast word appears on all four.

## Timing
- Reset (reset_n low, asynchronous assert):
  - All outK_valid = 0, all outK_data = 0, rr_ptr = 0.
  - in_ready reflects the empty slots, so it is 1 for any target.
- Reset release is synchronous to clock: the first edge with reset_n high is the first operating edge.
- Reset mid-operation: words held in slots are discarded. No partial state survives.
- Latency: a word accepted at edge N is visible on outK_data/outK_valid after edge N.
- Throughput:
  - One word per cycle into any one channel whose consumer holds ready high.
  - Up to one word per cycle overall.
  - Broadcast sustains one word per cycle only if all four readys are high.
- Simultaneous drain and load on the same slot in the same edge: the load wins, and valid stays 1 with the new data.
- Backpressure on one channel never stalls transfers targeting the other channels (in addressed or auto mode).

## Test plan
- Reset behaviour: assert reset_n = 0 mid-stream with out2_valid = 1 → all outK_valid = 0, all outK_data = 0, and in_ready = 1 immediately without waiting for a clock edge. After release, rr_ptr = 0.
- Addressed streaming:
  - Stimulus: NrOfBits = 8, BubblesMask = 4'b0100, in_sel = 2, out3_ready held 1, data 0x00..0x0F, one word per cycle.
  - Response: out3_data = 0xFF..0xF0 (inverted), one cycle after each accept, 16 consecutive valid cycles.
  - Other channels: valid stays 0.
- Backpressure:
  - Stimulus: out1_ready = 0, send 0xA5 to ch1, then 0x3C to ch1.
  - Response: out1 holds 0xA5, in_ready = 0 for the second word.
  - Stimulus: raise out1_ready.
  - Response: in that same edge 0xA5 drains and 0x3C loads, so out1_valid never drops.
- Round-robin: in_auto = 1, all readys 1, send 0x11, 0x22, 0x33, 0x44, 0x55 → ch1..ch4 get 0x11..0x44, then ch1 gets 0x55 (pointer wrap).
- Broadcast gating:
  - Stimulus: out4_valid = 1 with out4_ready = 0, in_bcast = 1 with 0x5A.
  - Response: in_ready = 0, and no slot changes.
  - Stimulus: release out4_ready.
  - Response: all four channels show 0x5A (inverted where the mask is set), and rr_ptr is unchanged.
- Mode priority: in_bcast = 1, in_auto = 1, in_sel = 1 simultaneously → broadcast occurs and rr_ptr does not advance.

Source files
------------

// File: rtl/bus_distributor_4_outputs.sv
// bus_distributor_4_outputs: registered 1-to-4 fan-out with valid/ready
// handshakes. Each accepted word goes to one addressed channel, to the
// round-robin channel, or to all four channels. Per-channel bubble inversion
// is applied as the word is loaded into its output slot.
module bus_distributor_4_outputs #(
  parameter int          NrOfBits    = 1,
  parameter logic [3:0]  BubblesMask = 4'b0000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NrOfBits-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic                in_auto,
  input  logic                in_bcast,
  output logic [NrOfBits-1:0] out1_data,
  output logic                out1_valid,
  input  logic                out1_ready,
  output logic [NrOfBits-1:0] out2_data,
  output logic                out2_valid,
  input  logic                out2_ready,
  output logic [NrOfBits-1:0] out3_data,
  output logic                out3_valid,
  input  logic                out3_ready,
  output logic [NrOfBits-1:0] out4_data,
  output logic                out4_valid,
  input  logic                out4_ready
);

  logic [NrOfBits-1:0] data_q [4];
  logic [NrOfBits-1:0] data_d [4];
  logic [3:0]          valid_q;
  logic [3:0]          valid_d;
  logic [1:0]          rr_ptr_q;
  logic [1:0]          rr_ptr_d;

  logic [3:0]          out_ready;
  logic [3:0]          slot_free;
  logic [3:0]          target;
  logic                xfer;

  assign out_ready = {out4_ready, out3_ready, out2_ready, out1_ready};

  // Target selection and acceptance: broadcast needs every slot free, other
  // modes only need the one targeted slot free (a draining slot counts as free).
  always_comb begin
    slot_free = ~valid_q | out_ready;
    target    = 4'b0000;
    in_ready  = 1'b0;
    if (in_bcast) begin
      target   = 4'b1111;
      in_ready = &slot_free;
    end else if (in_auto) begin
      target   = 4'b0001 << rr_ptr_q;
      in_ready = |(target & slot_free);
    end else begin
      target   = 4'b0001 << in_sel;
      in_ready = |(target & slot_free);
    end
    xfer = in_valid && in_ready;
  end

  // Slot update: a load wins over a drain, a drained slot keeps its old data,
  // and the pointer only advances on auto-mode transfers.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      data_d[k]  = data_q[k];
      valid_d[k] = valid_q[k];
      if (xfer && target[k]) begin
        data_d[k]  = in_data ^ {NrOfBits{BubblesMask[k]}};
        valid_d[k] = 1'b1;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (xfer && !in_bcast && in_auto) begin
      rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  // Slot and pointer registers; reset discards any held words.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
      valid_q  <= 4'b0000;
      rr_ptr_q <= 2'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out1_data  = data_q[0];
  assign out2_data  = data_q[1];
  assign out3_data  = data_q[2];
  assign out4_data  = data_q[3];
  assign out1_valid = valid_q[0];
  assign out2_valid = valid_q[1];
  assign out3_valid = valid_q[2];
  assign out4_valid = valid_q[3];

endmodule
